frame_decode: RTL and testbench
===============================

# frame_decode

Consumes the PCD→PICC Modified Miller sequence stream produced by `sequence_decode` (`seq`, `seq_valid`, `idle`) and converts it to frame-level events: start of communication, decoded data bits, end of communication and errors. It sits directly downstream of `sequence_decode` in the ISO/IEC 14443A receive path and feeds the bit/byte assembly logic. It runs in the same clock domain, so no synchronisation is needed.

## Interface
- `BIT_COUNT_WIDTH`, 10, width of the frame bit counter; the counter saturates at all-ones.
- `clk` in 1: system clock, the same clock as `sequence_decode`.
- `rst` in 1: reset, asynchronous, active-high.
- `seq` in PCDBitSequence: sequence from `sequence_decode` (X/Y/Z/ERROR).
- `seq_valid` in 1: `seq` is valid this cycle; single-cycle pulse.
- `idle` in 1: `sequence_decode` is idle.
- `soc` out 1: start of communication; single-cycle pulse.
- `eoc` out 1: valid end of communication; single-cycle pulse.
- `data_bit` out 1: decoded bit; qualified by `data_valid`.
- `data_valid` out 1: `data_bit` is valid; single-cycle pulse.
- `bit_count` out BIT_COUNT_WIDTH: bits emitted since the last `soc`.
- `error` out 1: framing error; single-cycle pulse.
- `is_parity` out 1: qualifies `data_valid`; high when the emitted bit is a parity bit.
- `parity_error` out 1: odd-parity mismatch; single-cycle pulse.

## Operation
- Decoding rules:
  - Z is SOC when the block is idle.
  - In a frame, X = 1.
  - Z = 0 when the previous sequence was SOC or a 0.
  - Y = 0 when the previous bit was 1.
  - Y after a 0 = EOC.
- Because EOC is "logic 0 + Y", every bit is held as a pending bit for one sequence and emitted only when the next sequence proves it is data. A pending 0 followed by Y is discarded and `eoc` pulses.
- States:
  - IDLE: a Z moves to SOF_SEEN with `soc`=1 and `bit_count`=0. All other sequences are ignored.
  - SOF_SEEN: X or Z sets the pending bit and moves to DATA. Y or ERROR gives `error` and moves to DRAIN.
  - DATA: X or Z, or Y after a pending 1, emits the pending bit, stores the new one and stays in DATA. Y after a pending 0 gives `eoc` and moves to DRAIN. ERROR gives `error` and moves to DRAIN.
  - DRAIN: all `seq_valid` are ignored. Moves to IDLE when `idle`=1.
- If `idle` rises while in SOF_SEEN or DATA, the block gives `error`, drops the pending bit and goes to IDLE.
- ERROR and idle in the same cycle: one `error` pulse only.
- `bit_count` increments on every `data_valid`, saturates, and holds until the next `soc`.
- Reset values:
  - State = IDLE.
  - All pulse outputs = 0, `data_bit`=0, `bit_count`=0.
  - Pending bit cleared.
- Reset asserted mid-frame drops the frame with no `error` or `eoc`.

## Timing
- All outputs are registered.
- Each event fires 1 cycle after the `seq_valid` that causes it:
  - `soc` after the SOC Z.
  - `data_valid` for bit n after the sequence of bit n+1.
  - `eoc` after the terminating Y.
  - `error` after ERROR, or 1 cycle after `idle` rises.
- At most one of `soc`/`eoc`/`error` is high per cycle. `data_valid` never coincides with `soc`, `eoc` or `error`.
- `bit_count` updates in the same cycle as `data_valid`.
- No back-pressure: the consumer must accept every pulse.

## Configuration
- `FRAME_DECODE_PARITY_EN` defined:
  - Bits are counted mod 9 from `soc`; every 9th bit drives `is_parity`=1.
  - A running XOR covers the 8 preceding bits. If the XOR of those 8 bits and the parity bit is 0, `parity_error` pulses with that `data_valid`.
  - The frame continues after a parity error.
- Not defined: `is_parity` and `parity_error` are tied to 0 and there is no mod-9 counter.

## Test plan
- REQA, sequences Z Z X X Y Z X Y Z Y Y → `soc`; `data_valid` bits 0,1,1,0,0,1,0; `bit_count`=7; `eoc`; no `error`.
- Z X Z (sequence_decode emits ERROR at the X→Z) → `soc`, `error` once; bit 1 is not emitted; no `eoc`; the block returns to IDLE when `idle`=1.
- Z Y Y → `soc` then `error`; 0 bits emitted.
- 0x93 0x20 with correct odd parity, macro on → 18 bits with `is_parity` at bits 9 and 18; `parity_error`=0. Flipping bit 9 gives `parity_error`=1 at bit 9 only.
- Assert `rst` after 5 bits of a frame → all outputs 0 immediately. A subsequent REQA decodes cleanly.
- Frame of 1100 X sequences with `BIT_COUNT_WIDTH`=10 → `bit_count` saturates at 1023; the final `eoc` still fires.

Source files
------------

// File: rtl/frame_decode.sv
// frame_decode: turns Modified Miller sequences (X/Y/Z/ERROR) into SOC, data bit, EOC and error events.
// Define FRAME_DECODE_PARITY_EN to mark every 9th bit as parity and check odd parity.
module frame_decode #(
  parameter int BIT_COUNT_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 seq,
  input  logic                       seq_valid,
  input  logic                       idle,
  output logic                       soc,
  output logic                       eoc,
  output logic                       data_bit,
  output logic                       data_valid,
  output logic [BIT_COUNT_WIDTH-1:0] bit_count,
  output logic                       error,
  output logic                       is_parity,
  output logic                       parity_error
);

  localparam logic [1:0] SEQ_X   = 2'd0;
  localparam logic [1:0] SEQ_Y   = 2'd1;
  localparam logic [1:0] SEQ_Z   = 2'd2;
  localparam logic [1:0] SEQ_ERR = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    SOF_SEEN,
    DATA,
    DRAIN
  } state_t;

  state_t state;
  logic   pend;
  logic   idle_q;
  logic   idle_rise;
  logic   cnt_full;

  assign idle_rise = idle && !idle_q;
  assign cnt_full  = &bit_count;

`ifdef FRAME_DECODE_PARITY_EN
  logic [3:0] mod9;
  logic       par_acc;
`else
  assign is_parity    = 1'b0;
  assign parity_error = 1'b0;
`endif

  // A bit stays pending until the next sequence shows it is not the EOC zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      pend       <= 1'b0;
      idle_q     <= 1'b0;
      soc        <= 1'b0;
      eoc        <= 1'b0;
      error      <= 1'b0;
      data_valid <= 1'b0;
      data_bit   <= 1'b0;
      bit_count  <= '0;
`ifdef FRAME_DECODE_PARITY_EN
      mod9         <= 4'd0;
      par_acc      <= 1'b0;
      is_parity    <= 1'b0;
      parity_error <= 1'b0;
`endif
    end else begin
      soc        <= 1'b0;
      eoc        <= 1'b0;
      error      <= 1'b0;
      data_valid <= 1'b0;
`ifdef FRAME_DECODE_PARITY_EN
      is_parity    <= 1'b0;
      parity_error <= 1'b0;
`endif
      idle_q <= idle;
      unique case (state)
        IDLE: begin
          if (seq_valid && seq == SEQ_Z) begin
            soc       <= 1'b1;
            bit_count <= '0;
            pend      <= 1'b0;
            state     <= SOF_SEEN;
`ifdef FRAME_DECODE_PARITY_EN
            mod9    <= 4'd0;
            par_acc <= 1'b0;
`endif
          end
        end
        SOF_SEEN: begin
          if (idle_rise) begin
            error <= 1'b1;
            pend  <= 1'b0;
            state <= IDLE;
          end else if (seq_valid) begin
            if (seq == SEQ_X || seq == SEQ_Z) begin
              pend  <= (seq == SEQ_X);
              state <= DATA;
            end else begin
              error <= 1'b1;
              state <= DRAIN;
            end
          end
        end
        DATA: begin
          if (idle_rise) begin
            error <= 1'b1;
            pend  <= 1'b0;
            state <= IDLE;
          end else if (seq_valid) begin
            if (seq == SEQ_ERR) begin
              error <= 1'b1;
              pend  <= 1'b0;
              state <= DRAIN;
            end else if (seq == SEQ_Y && !pend) begin
              eoc   <= 1'b1;
              pend  <= 1'b0;
              state <= DRAIN;
            end else begin
              data_valid <= 1'b1;
              data_bit   <= pend;
              pend       <= (seq == SEQ_X);
              if (!cnt_full) begin
                bit_count <= bit_count + 1'b1;
              end
`ifdef FRAME_DECODE_PARITY_EN
              if (mod9 == 4'd8) begin
                is_parity    <= 1'b1;
                parity_error <= ~(par_acc ^ pend);
                mod9         <= 4'd0;
                par_acc      <= 1'b0;
              end else begin
                mod9    <= mod9 + 1'b1;
                par_acc <= par_acc ^ pend;
              end
`endif
            end
          end
        end
        DRAIN: begin
          if (idle) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_decode.sv
// tb_frame_decode: table vectors, directed corner cases and random frames
// checked against a bit-list model of the frame decoder.
module tb_frame_decode;

  localparam int W    = 10;
  localparam int CMAX = (1 << W) - 1;
  localparam logic [1:0] SX = 2'd0;
  localparam logic [1:0] SY = 2'd1;
  localparam logic [1:0] SZ = 2'd2;
  localparam logic [1:0] SE = 2'd3;
`ifdef FRAME_DECODE_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [1:0]   seq = 2'd0;
  logic         seq_valid = 1'b0;
  logic         idle = 1'b0;
  logic         soc, eoc, data_bit, data_valid, error;
  logic         is_parity, parity_error;
  logic [W-1:0] bit_count;

  frame_decode #(.BIT_COUNT_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .seq(seq), .seq_valid(seq_valid),
    .idle(idle), .soc(soc), .eoc(eoc), .data_bit(data_bit),
    .data_valid(data_valid), .bit_count(bit_count), .error(error),
    .is_parity(is_parity), .parity_error(parity_error)
  );

  always #5 clk = ~clk;

  int pass_n = 0;
  int total_n = 0;
  int soc_n, eoc_n, err_n;
  int excl_bad = 0;
  bit obs_bits[$];
  bit obs_par[$];
  bit obs_perr[$];

  typedef struct {
    string      name;
    string      ops;
    int         n_bits;
    logic [15:0] bits;
    int         socs;
    int         eocs;
    int         errs;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input longint act, input longint exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (int'(soc) + int'(eoc) + int'(error) > 1) excl_bad++;
      if (data_valid && (soc || eoc || error)) excl_bad++;
      if (!data_valid && (is_parity || parity_error)) excl_bad++;
      if (soc) begin
        soc_n++;
        check("soc bit_count", bit_count, 0);
      end
      if (eoc) eoc_n++;
      if (error) err_n++;
      if (data_valid) begin
        obs_bits.push_back(data_bit);
        obs_par.push_back(is_parity);
        obs_perr.push_back(parity_error);
        check("bit_count step", bit_count,
              (obs_bits.size() > CMAX) ? CMAX : obs_bits.size());
      end
    end
  end

  task automatic clear_obs();
    soc_n = 0;
    eoc_n = 0;
    err_n = 0;
    obs_bits.delete();
    obs_par.delete();
    obs_perr.delete();
  endtask

  task automatic send(input logic [1:0] s, input bit with_idle);
    @(posedge clk);
    #1;
    seq = s;
    seq_valid = 1'b1;
    if (with_idle) idle = 1'b1;
    @(posedge clk);
    #1;
    seq_valid = 1'b0;
    seq = 2'($urandom_range(0, 3));
    repeat ($urandom_range(0, 2)) @(posedge clk);
  endtask

  task automatic finish_frame();
    @(posedge clk);
    #1;
    idle = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    idle = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic run_ops(input string ops);
    for (int i = 0; i < ops.len(); i++) begin
      case (ops.getc(i))
        "X": send(SX, 1'b0);
        "Y": send(SY, 1'b0);
        "Z": send(SZ, 1'b0);
        "E": send(SE, 1'b0);
        "B": send(SE, 1'b1);
        default: ;
      endcase
    end
  endtask

  task automatic compare_frame(input string name, input bit exp[$],
                               input int es, input int ee, input int er);
    int bad = 0;
    int pbad = 0;
    int n;
    bit ep, epe, x;
    check({name, " soc"}, soc_n, es);
    check({name, " eoc"}, eoc_n, ee);
    check({name, " error"}, err_n, er);
    check({name, " nbits"}, obs_bits.size(), exp.size());
    n = (obs_bits.size() < exp.size()) ? obs_bits.size() : exp.size();
    for (int i = 0; i < n; i++) begin
      if (obs_bits[i] != exp[i]) bad++;
      ep = PAR_EN && (i % 9 == 8);
      x = 1'b0;
      if (ep) for (int k = i - 8; k <= i; k++) x ^= exp[k];
      epe = ep && !x;
      if (obs_par[i] != ep || obs_perr[i] != epe) pbad++;
    end
    check({name, " bit errors"}, bad, 0);
    check({name, " parity flags"}, pbad, 0);
    check({name, " bit_count"}, bit_count,
          (exp.size() > CMAX) ? CMAX : exp.size());
  endtask

  task automatic run_vec(input int v);
    bit exp[$];
    for (int i = 0; i < vecs[v].n_bits; i++) exp.push_back(vecs[v].bits[i]);
    clear_obs();
    run_ops(vecs[v].ops);
    finish_frame();
    compare_frame(vecs[v].name, exp, vecs[v].socs, vecs[v].eocs, vecs[v].errs);
  endtask

  // Encode a bit list as a complete frame: SOC, bits, then logic 0 + Y.
  task automatic run_bits(input string name, input bit bits[$]);
    string s = "Z";
    bit prev1 = 1'b0;
    foreach (bits[i]) begin
      if (bits[i]) s = {s, "X"};
      else s = {s, prev1 ? "Y" : "Z"};
      prev1 = bits[i];
    end
    s = {s, prev1 ? "Y" : "Z", "Y"};
    clear_obs();
    run_ops(s);
    finish_frame();
    compare_frame(name, bits, 1, 1, 0);
  endtask

  function automatic int count_ones(input bit q[$]);
    int c = 0;
    foreach (q[i]) c += int'(q[i]);
    return c;
  endfunction

  initial begin
    bit b[$];
    logic [7:0] by;
    vecs[0] = '{"reqa", "ZZXXYZXYZYY", 7, 16'h0026, 1, 1, 0};
    vecs[1] = '{"err_xz", "ZXE", 0, 16'h0000, 1, 0, 1};
    vecs[2] = '{"sof_y", "ZYY", 0, 16'h0000, 1, 0, 1};
    vecs[3] = '{"ones", "ZXXYY", 2, 16'h0003, 1, 1, 0};
    vecs[4] = '{"noise", "XYZZY", 0, 16'h0000, 1, 1, 0};
    vecs[5] = '{"err_zz", "ZZE", 0, 16'h0000, 1, 0, 1};
    vecs[6] = '{"idle_mid", "ZXX", 1, 16'h0001, 1, 0, 1};
    vecs[7] = '{"err_idle", "ZXB", 0, 16'h0000, 1, 0, 1};
    vecs[8] = '{"y_after1", "ZXYXYY", 3, 16'h0005, 1, 1, 0};

    repeat (3) @(posedge clk);
    #1;
    check("reset bit_count", bit_count, 0);
    check("reset outputs",
          {soc, eoc, error, data_valid, data_bit, is_parity, parity_error}, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 9; v++) run_vec(v);

    b.delete();
    foreach (by[k]) ;
    by = 8'h93;
    for (int k = 0; k < 8; k++) b.push_back(by[k]);
    b.push_back(~^by);
    by = 8'h20;
    for (int k = 0; k < 8; k++) b.push_back(by[k]);
    b.push_back(~^by);
    run_bits("par_ok", b);
    check("par_ok is_parity count", count_ones(obs_par), PAR_EN ? 2 : 0);
    check("par_ok parity_error count", count_ones(obs_perr), 0);
    b[8] = ~b[8];
    run_bits("par_flip", b);
    check("par_flip parity_error count", count_ones(obs_perr), PAR_EN ? 1 : 0);
    check("par_flip error at bit 9", obs_perr.size() > 8 ? obs_perr[8] : 0, PAR_EN);

    clear_obs();
    run_ops("ZXXXXXX");
    @(posedge clk);
    #1;
    check("pre-reset bit_count", bit_count, 5);
    check("pre-reset data_bit", data_bit, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid reset bit_count", bit_count, 0);
    check("mid reset outputs",
          {soc, eoc, error, data_valid, data_bit, is_parity, parity_error}, 0);
    check("mid reset no eoc/error", eoc_n + err_n, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_vec(0);

    for (int f = 0; f < 30; f++) begin
      b.delete();
      repeat ($urandom_range(0, 40)) b.push_back(1'($urandom));
      run_bits($sformatf("rand%0d", f), b);
    end

    b.delete();
    repeat (1100) b.push_back(1'b1);
    run_bits("saturate", b);

    check("pulse exclusivity", excl_bad, 0);
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
